// File: rtl/sobel_window_gen.sv
`default_nettype none
// ============================================================================
// Module   : sobel_window_gen
// Purpose  : Builds 3x3 neighbourhoods from a raster-order grayscale pixel
//            stream for sobel_core. Two line buffers hold the previous two
//            lines; one registered window is emitted per fully populated
//            3x3 neighbourhood (no border padding).
// Ports    : clk_i           - clock, all state on rising edge
//            nreset_i        - asynchronous active-low reset
//            pixel_i         - grayscale input pixel
//            pixel_valid_i   - pixel_i valid
//            sof_i           - frame start qualifier (with pixel_valid_i)
//            pixel_ready_o   - block accepts a pixel this cycle
//            matrix_pixels_o - 3x3 window, [vector][pix]; vector0 = top row,
//                              pix0 = left column
//            matrix_valid_o  - window valid
//            matrix_ready_i  - downstream accepts the window
//            last_o          - final window of the frame
// Revision : 1.0 - initial release
// ============================================================================
module sobel_window_gen #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int PIX_W      = 8
) (
  input  logic                        clk_i,
  input  logic                        nreset_i,
  input  logic [PIX_W-1:0]            pixel_i,
  input  logic                        pixel_valid_i,
  input  logic                        sof_i,
  output logic                        pixel_ready_o,
  output logic [2:0][2:0][PIX_W-1:0]  matrix_pixels_o,
  output logic                        matrix_valid_o,
  input  logic                        matrix_ready_i,
  output logic                        last_o
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  // Position counters
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;

  // Line buffers: lb1 holds line r-1, lb2 holds line r-2 (not reset)
  logic [PIX_W-1:0] lb1_q [IMG_WIDTH];
  logic [PIX_W-1:0] lb2_q [IMG_WIDTH];

  // Two previous columns of the neighbourhood, [row][0]=col c-2, [row][1]=col c-1
  logic [2:0][1:0][PIX_W-1:0] hist_q;

  // Output register
  logic [2:0][2:0][PIX_W-1:0] matrix_q;
  logic                       valid_q;
  logic                       last_q;

  logic             accept;
  logic             emit;
  logic             at_last;
  logic [CW-1:0]    pos_c;
  logic [RW-1:0]    pos_r;
  logic [2:0][PIX_W-1:0] new_col;   // [0]=top (r-2), [2]=bottom (current row)

  assign pixel_ready_o = !valid_q || matrix_ready_i;
  assign accept        = pixel_valid_i && pixel_ready_o;

  // sof_i overrides the counters so a stream can resynchronise at any point
  assign pos_c = sof_i ? '0 : col_q;
  assign pos_r = sof_i ? '0 : row_q;

  assign new_col[0] = lb2_q[pos_c];
  assign new_col[1] = lb1_q[pos_c];
  assign new_col[2] = pixel_i;

  // Windows only at c>=2, so the column history never spans a line wrap
  assign emit    = accept && (pos_r >= RW'(2)) && (pos_c >= CW'(2));
  assign at_last = (pos_r == RW'(IMG_HEIGHT - 1)) && (pos_c == CW'(IMG_WIDTH - 1));

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (pos_c == CW'(IMG_WIDTH - 1)) begin
        col_d = '0;
        row_d = (pos_r == RW'(IMG_HEIGHT - 1)) ? '0 : pos_r + RW'(1);
      end else begin
        col_d = pos_c + CW'(1);
        row_d = pos_r;
      end
    end
  end

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      lb2_q[pos_c] <= lb1_q[pos_c];
      lb1_q[pos_c] <= pixel_i;
    end
  end

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      hist_q <= '0;
    end else if (accept) begin
      for (int v = 0; v < 3; v++) begin
        hist_q[v][0] <= hist_q[v][1];
        hist_q[v][1] <= new_col[v];
      end
    end
  end

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      matrix_q <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
    end else if (emit) begin
      for (int v = 0; v < 3; v++) begin
        matrix_q[v][0] <= hist_q[v][0];
        matrix_q[v][1] <= hist_q[v][1];
        matrix_q[v][2] <= new_col[v];
      end
      valid_q <= 1'b1;
      last_q  <= at_last;
    end else if (matrix_ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign matrix_pixels_o = matrix_q;
  assign matrix_valid_o  = valid_q;
  assign last_o          = last_q;

endmodule
`default_nettype wire

// File: doc/sobel_window_gen.md
Name: sobel_window_gen

Overview:
- Produces the 3x3 neighbourhood that sobel_core consumes.
- Accepts a raster-order grayscale pixel stream and buffers two previous image lines in internal line buffers.
- Emits one registered sobel_matrix window per fully populated 3x3 neighbourhood, with a valid/ready handshake.
- Sits between the grayscale converter output and sobel_core's matrix_pixels_i.

Parameters:
- IMG_WIDTH, 640, pixels per line. Minimum 3.
- IMG_HEIGHT, 480, lines per frame. Minimum 3.
- PIX_W, width of one pixel field of sobel_matrix as defined in sobel_control.svh; grayscale pixel width.

Ports:
- clk_i  input  1  single clock; all state on rising edge.
- nreset_i  input  1  reset, asynchronous assert, active-low.
- pixel_i  input  PIX_W  grayscale input pixel.
- pixel_valid_i  input  1  pixel_i valid.
- sof_i  input  1  qualifies the pixel as frame start (row 0, col 0); sampled only with pixel_valid_i.
- pixel_ready_o  output  1  block can accept a pixel this cycle.
- matrix_pixels_o  output  sobel_matrix  3x3 window.
  - vector0 = top row, vector2 = bottom row.
  - pix0 = left column, pix2 = right column.
- matrix_valid_o  output  1  matrix_pixels_o valid.
- matrix_ready_i  input  1  downstream accepts the window.
- last_o  output  1  window is the final window of the frame; qualified by matrix_valid_o.

Behaviour:
- **Reset** (nreset_i low): matrix_valid_o=0, last_o=0, matrix_pixels_o all zero, column counter=0, row counter=0, window shift registers zero. Line-buffer RAM contents are not cleared; their contents are don't-care until rows 0 and 1 of the next frame have refilled them. Reset mid-frame abandons the frame; the next accepted pixel is treated as (0,0).
- **Input ready**: pixel_ready_o = !matrix_valid_o || matrix_ready_i. This is a combinational pass-through of matrix_ready_i; the output register holds one window.
- **Acceptance**: a pixel is accepted when pixel_valid_i && pixel_ready_o.
- **Pixel position**: each accepted pixel has position (r,c) from the counters. If sof_i=1, the pixel is forced to (0,0) regardless of counter state, and the counters continue from there.
- **Counter update** after acceptance:
  - c increments.
  - At c=IMG_WIDTH-1: c→0, r increments.
  - At r=IMG_HEIGHT-1 and c=IMG_WIDTH-1: both → 0, ready for the next frame with no idle cycle.
- **Line buffers**: two IMG_WIDTH-deep buffers, LB1 (line r-1) and LB2 (line r-2), read and written at address c. On acceptance:
  - LB2[c] ← LB1[c]; LB1[c] ← pixel_i.
  - The three column samples (LB2[c], LB1[c], pixel_i) shift into the 3x3 register: col2←new, col1←col2, col0←col1.
- **Window emission**: acceptance at (r,c) with r≥2 and c≥2 loads the output register on the same edge, giving 1-cycle latency. Contents:
  - vector0 = {pix0,pix1,pix2} = row r-2, cols c-2..c.
  - vector1 = row r-1, cols c-2..c.
  - vector2 = row r, cols c-2..c.
- **Window count**: (IMG_WIDTH-2)*(IMG_HEIGHT-2) windows per frame.
- **Borders**: no padding. Pixels at c<2 or r<2 update buffers and shift registers but produce no window.
- **Line wrap**: the shift register never mixes lines, because no window is emitted at c=0 or c=1.
- **Valid/last handshake**:
  - matrix_valid_o sets on an emitting acceptance.
  - It clears on matrix_ready_i when no new window loads in the same cycle.
  - Simultaneous drain and load gives back-to-back valid.
  - last_o=1 exactly for the window from (IMG_HEIGHT-1, IMG_WIDTH-1).
- **Stability**: matrix_pixels_o, matrix_valid_o and last_o are held stable while matrix_valid_o && !matrix_ready_i.
- **RAM timing**: line buffers are synchronous-read RAM or registers. If synchronous-read RAM is used, the read address is presented one cycle early (next c) so emission latency stays exactly 1 cycle.

Test Plan (IMG_WIDTH=4, IMG_HEIGHT=3 unless noted):
- **Basic frame**: stream pixels 0..11, sof_i on pixel 0, matrix_ready_i=1, continuous valid → exactly 2 windows, in the cycle after pixels 10 and 11 are accepted.
  - Window 1: {0,1,2},{4,5,6},{8,9,10}, last_o=0.
  - Window 2: {1,2,3},{5,6,7},{9,10,11}, last_o=1.
- **Backpressure**: same stream, matrix_ready_i held 0 for 5 cycles after window 1 → pixel_ready_o=0, window 1 held unchanged, pixel 11 not accepted until release; window 2 follows correctly.
- **Back-to-back frames**: two frames, values 0..11 then 100..111, no gap → second-frame windows {100,101,102},{104,105,106},{108,109,110} and {101,102,103},{105,106,107},{109,110,111}; no window straddles frames.
- **Resync**: 5 pixels of a frame, then sof_i with pixel 0 of a new 0..11 frame → output identical to the basic-frame test.
- **Mid-frame reset**: nreset_i low after 7 pixels → outputs zero immediately (asynchronous); a fresh 0..11 frame afterwards yields the basic-frame windows.
- **Integration**: IMG_WIDTH=IMG_HEIGHT=5, random valid/ready, output fed to sobel_core → 9 windows matching a software 3x3 extractor, and sobel_core results matching a golden model.
